tt_um_logic_pipe: RTL and testbench
===================================

// Module: tt_um_logic_pipe
// PURPOSE
//  Parametrised successor to the fixed 8-bit AND tile. Applies a selectable bitwise op
//  (AND/OR/XOR/NAND) to two WIDTH-bit operands, or folds a stream into an accumulator.
//  Results pass through a STAGES-deep elastic pipeline with valid/ready handshakes.
//  The TT top wrapper maps ui_in to a and uio_in to b, and drives uo_out from y.
// PARAMETERS
//  WIDTH   8  operand/result width in bits, >=1
//  STAGES  2  pipeline depth in register stages, 1..4
//  CNT_W   8  width of the delivered-beat counter
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  reset      in   1        synchronous, active-high reset
//  a          in   WIDTH    operand A
//  b          in   WIDTH    operand B; ignored when acc_en=1
//  op         in   2        00 AND, 01 OR, 10 XOR, 11 NAND
//  acc_en     in   1        1: result = acc OP a, and acc is updated with the result
//  acc_clr    in   1        load the accumulator with all-ones
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block can accept a beat
//  y          out  WIDTH    result
//  out_valid  out  1        y valid
//  out_ready  in   1        downstream accepts y
//  beat_cnt   out  CNT_W    count of delivered beats; wraps
//  popcnt     out  $clog2(WIDTH+1)  ones count of y (only with LOGIC_POPCNT_EN)
// BEHAVIOUR
//  - Reset: every stage valid=0, y=0, out_valid=0, acc={WIDTH{1'b1}}, beat_cnt=0.
//    in_ready=1 in the first cycle after reset.
//  - Reset takes priority over all other inputs. Beats in flight are dropped with no
//    output.
//  - Accept: a beat is accepted when in_valid & in_ready. Deliver: a beat is delivered
//    when out_valid & out_ready.
//  - Op and operands are sampled only at accept. Result = a OP (acc_en ? acc : b),
//    computed combinationally and registered into stage 0.
//  - Stage i loads from stage i-1 when stage i is empty or stage i is advancing.
//    The last stage advances when out_ready=1.
//  - in_ready = !s0_valid | s0_advancing. This is a full-throughput chain with no
//    bubbles under continuous out_ready.
//  - Latency: the beat accepted at edge N has out_valid=1 after edge N+STAGES-1,
//    provided out_ready stayed 1.
//  - Backpressure: with out_ready=0 the pipe fills. After STAGES beats are held,
//    in_ready=0. y and out_valid stay stable while out_ready=0.
//  - Accumulator: on an accept with acc_en=1, acc <= result. It is not updated on a
//    non-accepted cycle.
//  - Back-to-back accumulate beats see the updated acc, with no hazard.
//  - acc_clr: acc <= all-ones on that edge, regardless of in_valid. If acc_clr is high
//    in the same cycle as an accumulate accept, that beat uses the old acc and acc_clr
//    wins the update.
//  - beat_cnt increments by 1 per delivery. It wraps from 2^CNT_W-1 to 0.
//  - Arithmetic: bitwise only, no carries; all vectors are WIDTH bits. NAND = ~(x & y).
//  - Op and acc_en may change every cycle. Each beat carries its own op; no mode state
//    is kept beyond acc.
// CONFIGURATION
//  - LOGIC_POPCNT_EN defined: popcnt is a registered output that travels with y (same
//    latency and stall behaviour); reset value 0.
//  - LOGIC_POPCNT_EN undefined: the popcnt port and its logic are absent.
// TESTING (WIDTH=8, STAGES=2)
//  - Reset=1 for 2 cycles, then release -> out_valid=0, y=0, beat_cnt=0, in_ready=1.
//  - Accept a=F0, b=3C, op=00, out_ready=1 -> y=30 with out_valid=1 one cycle after
//    accept, then beat_cnt=1.
//  - Accept 4 beats with op=01,10,11,00 on a=AA, b=0F, out_ready=1 -> y=AF,A5,F5,0A in
//    consecutive cycles, in_ready stays 1.
//  - out_ready=0, offer 3 beats -> only 2 accepted; in_ready=0; y is held stable.
//    Raise out_ready -> 3 beats delivered in order, none lost.
//  - acc_en=1, op=00, stream a=FE,7F,3C -> y=FE,7E,3C. Then acc_clr with an
//    accumulate beat a=0F -> y=0C and acc=FF.
//  - Deliver 256 beats -> beat_cnt wraps to 0. With LOGIC_POPCNT_EN, y=A5 gives
//    popcnt=4.

Source files
------------

// File: rtl/tt_um_logic_pipe.sv
// tt_um_logic_pipe: selectable bitwise op (AND/OR/XOR/NAND) on two operands, or a
// fold into a running accumulator. Results travel through an elastic valid/ready
// pipeline that is STAGES registers deep, and a counter tracks delivered beats.
// Optional feature macro: LOGIC_POPCNT_EN adds a registered ones-count of y that
// moves through the pipeline alongside y.
module tt_um_logic_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] beat_cnt
`ifdef LOGIC_POPCNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] popcnt
`endif
);

  logic [WIDTH-1:0]  data_q [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load_en;
  logic [WIDTH-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WIDTH-1:0]  operand_b;
  logic [WIDTH-1:0]  result;
  logic              accept;
  logic              deliver;

  // Per-stage load enable: a stage may load when some stage at or after it is
  // empty, or when the tail is draining. Walking back from the tail keeps the
  // ready chain bubble-free.
  always_comb begin
    logic go;
    load_en = '0;
    go      = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      go         = go | !valid_q[i];
      load_en[i] = go;
    end
  end

  assign in_ready  = load_en[0];
  assign accept    = in_valid & load_en[0];
  assign out_valid = valid_q[STAGES-1];
  assign y         = data_q[STAGES-1];
  assign deliver   = valid_q[STAGES-1] & out_ready;
  assign beat_cnt  = cnt_q;

  // Operand select and the bitwise op itself; the accumulator replaces b when folding.
  always_comb begin
    operand_b = acc_en ? acc_q : b;
    result    = '0;
    unique case (op)
      2'b00:   result = a & operand_b;
      2'b01:   result = a | operand_b;
      2'b10:   result = a ^ operand_b;
      default: result = ~(a & operand_b);
    endcase
  end

  // Pipeline registers: valids shift on load; data only moves when its source holds
  // a real beat, so y does not toggle on bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      if (load_en[0]) begin
        valid_q[0] <= accept;
        if (accept) data_q[0] <= result;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load_en[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

  // Accumulator: a clear beats a same-cycle fold, which still consumed the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '1;
    end else if (acc_clr) begin
      acc_q <= '1;
    end else if (accept && acc_en) begin
      acc_q <= result;
    end
  end

  // Delivered-beat counter, free-running wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (deliver) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef LOGIC_POPCNT_EN
  localparam int PCW = $clog2(WIDTH + 1);

  logic [PCW-1:0] pc_q [STAGES];

  function automatic logic [PCW-1:0] ones(input logic [WIDTH-1:0] v);
    logic [PCW-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) n = n + PCW'(v[i]);
    return n;
  endfunction

  // Ones count shadows the data path so it stalls and advances with y.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) pc_q[i] <= '0;
    end else begin
      if (accept) pc_q[0] <= ones(result);
      for (int i = 1; i < STAGES; i++) begin
        if (load_en[i] && valid_q[i-1]) pc_q[i] <= pc_q[i-1];
      end
    end
  end

  assign popcnt = pc_q[STAGES-1];
`endif

endmodule

// File: tb/tb_tt_um_logic_pipe.sv
// Scoreboard bench for tt_um_logic_pipe (WIDTH=8, STAGES=2, CNT_W=8).
module tb_tt_um_logic_pipe;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] a, b;
  logic [1:0] op;
  logic       acc_en, acc_clr, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] y;
  logic [7:0] beat_cnt;
`ifdef LOGIC_POPCNT_EN
  logic [3:0] popcnt;
`endif

  tt_um_logic_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .a         (a),
    .b         (b),
    .op        (op),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_cnt  (beat_cnt)
`ifdef LOGIC_POPCNT_EN
    ,
    .popcnt    (popcnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] y;
    logic [3:0] pc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_deliv  = 0;
  int   w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic push_exp(input logic [7:0] ey);
    exp_t e;
    e.y  = ey;
    e.pc = 4'($countones(ey));
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] top,
                      input logic tacc, input logic tclr, input logic [7:0] ey,
                      output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    a = ta; b = tb_v; op = top; acc_en = tacc; acc_clr = tclr; in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    if (got) begin
      push_exp(ey);
      @(posedge clk); #1;
    end else begin
      n_checks++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end
    in_valid = 1'b0; acc_clr = 1'b0; acc_en = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 100; k++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    check({name, "_drained"}, {31'd0, (exp_q.size() == 0 && !out_valid)}, 32'd1);
    check({name, "_beat_cnt"}, beat_cnt, n_deliv[7:0]);
  endtask

  // Monitor: every delivered beat is popped and compared against the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_output: got y=%0h with no beat pending, required none", y);
      end else begin
        mon_e = exp_q.pop_front();
        check("y", y, mon_e.y);
`ifdef LOGIC_POPCNT_EN
        check("popcnt", popcnt, mon_e.pc);
`endif
      end
      n_deliv++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; a = '0; b = '0; op = '0; acc_en = 1'b0; acc_clr = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 8'h00);
    check("rst_beat_cnt", beat_cnt, 8'h00);
    check("rst_in_ready", in_ready, 1);
`ifdef LOGIC_POPCNT_EN
    check("rst_popcnt", popcnt, 0);
`endif
    @(posedge clk); #1;

    // Single AND beat with latency check
    send(8'hF0, 8'h3C, 2'b00, 1'b0, 1'b0, 8'h30, w);
    @(negedge clk);
    check("lat_not_yet", out_valid, 0);
    @(negedge clk);
    check("lat_valid", out_valid, 1);
    check("lat_y", y, 8'h30);
    @(posedge clk); #1;
    check("beat_cnt_1", beat_cnt, 8'h01);

    // Four ops back to back, full throughput
    send(8'hAA, 8'h0F, 2'b01, 1'b0, 1'b0, 8'hAF, w); check("tput_or",   w, 0);
    send(8'hAA, 8'h0F, 2'b10, 1'b0, 1'b0, 8'hA5, w); check("tput_xor",  w, 0);
    send(8'hAA, 8'h0F, 2'b11, 1'b0, 1'b0, 8'hF5, w); check("tput_nand", w, 0);
    send(8'hAA, 8'h0F, 2'b00, 1'b0, 1'b0, 8'h0A, w); check("tput_and",  w, 0);
    drain("tput");

    // Backpressure: two beats fit, third stalls, y held
    out_ready = 1'b0;
    a = 8'h11; b = 8'h22; op = 2'b01; in_valid = 1'b1;
    @(negedge clk); check("bp_rdy1", in_ready, 1); push_exp(8'h33);
    @(posedge clk); #1;
    a = 8'hC3; b = 8'h0F; op = 2'b10;
    @(negedge clk); check("bp_rdy2", in_ready, 1); push_exp(8'hCC);
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h81; op = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_full_rdy", in_ready, 0);
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_y", y, 8'h33);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk); check("bp_release_rdy", in_ready, 1); push_exp(8'h7E);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("bp");

    // Accumulate stream, clear collision, idle cycles must not touch acc
    send(8'hFE, 8'h00, 2'b00, 1'b1, 1'b0, 8'hFE, w);
    send(8'h7F, 8'h00, 2'b00, 1'b1, 1'b0, 8'h7E, w);
    send(8'h3C, 8'h00, 2'b00, 1'b1, 1'b0, 8'h3C, w);
    send(8'h0F, 8'h00, 2'b00, 1'b1, 1'b1, 8'h0C, w);
    send(8'h5A, 8'h00, 2'b00, 1'b1, 1'b0, 8'h5A, w);
    a = 8'h00; op = 2'b00; acc_en = 1'b1; in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    acc_en = 1'b0;
    send(8'hFF, 8'h00, 2'b00, 1'b1, 1'b0, 8'h5A, w);
    send(8'h0F, 8'h00, 2'b10, 1'b1, 1'b0, 8'h55, w);
    send(8'hF0, 8'h00, 2'b11, 1'b1, 1'b0, 8'hAF, w);
    drain("acc");

    // Reset with beats in flight drops them and restores acc
    out_ready = 1'b0;
    send(8'h11, 8'h22, 2'b00, 1'b0, 1'b0, 8'h00, w);
    send(8'hFF, 8'h0F, 2'b01, 1'b0, 1'b0, 8'hFF, w);
    reset = 1'b1;
    exp_q.delete();
    n_deliv = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("rst2_out_valid", out_valid, 0);
    check("rst2_beat_cnt", beat_cnt, 8'h00);
    check("rst2_y", y, 8'h00);
    @(posedge clk); #1;
    send(8'h3C, 8'h00, 2'b00, 1'b1, 1'b0, 8'h3C, w);
    drain("rst2");

    // Counter wrap
    send(8'hA5, 8'hFF, 2'b00, 1'b0, 1'b0, 8'hA5, w);
    for (int i = 0; n_deliv + exp_q.size() < 255; i++) begin
      send(8'(i), 8'hFF, 2'b10, 1'b0, 1'b0, ~8'(i), w);
    end
    drain("wrap_pre");
    check("beat_cnt_255", beat_cnt, 8'hFF);
    send(8'h0F, 8'hF0, 2'b01, 1'b0, 1'b0, 8'hFF, w);
    drain("wrap");
    check("beat_cnt_wrap", beat_cnt, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
